// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: sequencer state
// encoding, the active-low hex decode table and a counter-width helper.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // gfedcba, active low, indexed by nibble value 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_LUT[i_nibble];
  end

endmodule

// File: rtl/seg_phase_sequencer.sv
// Multi-digit seven-segment sequencer: steps through NUM_PHASES messages,
// each held for HOLD_TICKS slow ticks, while time-multiplexing the anodes.
module seg_phase_sequencer
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int NUM_PHASES = 3,
  parameter  int SCAN_DIV   = 100000,
  parameter  int TICK_DIV   = 25000000,
  parameter  int HOLD_TICKS = 4,
  localparam int PW         = $clog2(NUM_PHASES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             loop_mode,
  input  logic [NUM_DIGITS-1:0]            blank,
  input  logic [NUM_PHASES*NUM_DIGITS*4-1:0] phase_data,
  output logic [NUM_DIGITS-1:0]            an,
  output logic [6:0]                       seg,
  output logic [PW-1:0]                    phase,
  output logic                             done
);

  localparam int SCAN_W  = cnt_width(SCAN_DIV);
  localparam int TICK_W  = cnt_width(TICK_DIV);
  localparam int DWELL_W = cnt_width(HOLD_TICKS);
  localparam int DIG_W   = cnt_width(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_TICKS - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]      PHASE_LAST = PW'(NUM_PHASES - 1);

  if (HOLD_TICKS < 1) begin : g_bad_hold
    $fatal(1, "seg_phase_sequencer: HOLD_TICKS must be >= 1");
  end
  if (NUM_PHASES < 2) begin : g_bad_phases
    $fatal(1, "seg_phase_sequencer: NUM_PHASES must be >= 2");
  end

  seq_state_t            r_state;
  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [DIG_W-1:0]      r_scan;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [DWELL_W-1:0]    r_dwell;
  logic [PW-1:0]         r_phase;
  logic                  r_done;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  logic                  w_tick;
  logic [3:0]            w_nibble;
  logic [6:0]            w_dec;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [6:0]            w_seg_nxt;

  assign w_tick = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

  // Dropping start blanks the display on the same edge the FSM returns to idle.
  always_comb begin
    w_nibble  = phase_data[(int'(r_phase) * NUM_DIGITS + int'(r_scan)) * 4 +: 4];
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    if (start && (r_state != ST_IDLE) && !blank[r_scan]) begin
      w_an_nxt[r_scan] = 1'b0;
      w_seg_nxt        = w_dec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_scan_cnt <= '0;
      r_scan     <= '0;
      r_tick_cnt <= '0;
      r_dwell    <= '0;
      r_phase    <= '0;
      r_done     <= 1'b0;
      r_an       <= '1;
      r_seg      <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      if (!start) begin
        r_state    <= ST_IDLE;
        r_scan_cnt <= '0;
        r_scan     <= '0;
        r_tick_cnt <= '0;
        r_dwell    <= '0;
        r_phase    <= '0;
        r_done     <= 1'b0;
      end else begin
        if (r_state != ST_IDLE) begin
          if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan     <= (r_scan == DIG_LAST) ? '0 : r_scan + 1'b1;
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_RUN;
            r_scan_cnt <= '0;
            r_scan     <= '0;
            r_tick_cnt <= '0;
            r_dwell    <= '0;
            r_phase    <= '0;
            r_done     <= 1'b0;
          end
          ST_RUN: begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              if (r_dwell == DWELL_LAST) begin
                r_dwell <= '0;
                if (r_phase != PHASE_LAST) begin
                  r_phase <= r_phase + 1'b1;
                end else if (loop_mode) begin
                  r_phase <= '0;
                end else begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_dwell <= r_dwell + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            r_done <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign phase = r_phase;
  assign done  = r_done;

endmodule

// File: tb/tb_seg_phase_sequencer.sv
// Scoreboard bench for seg_phase_sequencer (4 digits, 3 phases, SCAN_DIV=4,
// TICK_DIV=8, HOLD_TICKS=2): stimulus queues expectations, a monitor checks them.
module tb_seg_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        loop_mode;
  logic [3:0]  blank;
  logic [47:0] phase_data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  phase;
  logic        done;

  seg_phase_sequencer #(
    .NUM_DIGITS (4),
    .NUM_PHASES (3),
    .SCAN_DIV   (4),
    .TICK_DIV   (8),
    .HOLD_TICKS (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .loop_mode  (loop_mode),
    .blank      (blank),
    .phase_data (phase_data),
    .an         (an),
    .seg        (seg),
    .phase      (phase),
    .done       (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int         c;
    string      nm;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] ph;
    logic       dn;
    logic [3:0] m;   // field mask: 0=an 1=seg 2=phase 3=done
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // phase 0 = 3210, phase 1 = 7654, phase 2 = BA98, by scan slot 0..3
  logic [6:0] seg_tab [3][4] = '{'{7'h40, 7'h79, 7'h24, 7'h30},
                                 '{7'h19, 7'h12, 7'h02, 7'h78},
                                 '{7'h00, 7'h10, 7'h08, 7'h03}};
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic push(input int c, input string nm, input logic [3:0] a,
                      input logic [6:0] s, input logic [1:0] p, input logic d,
                      input logic [3:0] m);
    exp_t e;
    e.c = c; e.nm = nm; e.an = a; e.seg = s; e.ph = p; e.dn = d; e.m = m;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int c, input string f,
                     input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d %s got=%h want=%h", nm, c, f, act, want);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.c < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed cyc=%0d got=none want=checked", e.nm, e.c);
      end else begin
        if (e.m[0]) chk(e.nm, e.c, "an",    {4'b0, an},    {4'b0, e.an});
        if (e.m[1]) chk(e.nm, e.c, "seg",   {1'b0, seg},   {1'b0, e.seg});
        if (e.m[2]) chk(e.nm, e.c, "phase", {6'b0, phase}, {6'b0, e.ph});
        if (e.m[3]) chk(e.nm, e.c, "done",  {7'b0, done},  {7'b0, e.dn});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    int s;
    int p;
    int pn;
    exp_t e;
    reset      = 1'b1;
    start      = 1'b0;
    loop_mode  = 1'b1;
    blank      = 4'b0000;
    phase_data = {16'hBA98, 16'h7654, 16'h3210};
    push(1, "reset_init", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    step(2);
    reset = 1'b0;
    step(1);

    // Looping run: scan pattern and phase timing (edge base is the RUN entry)
    base = cyc + 1;
    start = 1'b1;
    loop_mode = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      s  = ((k - 1) / 4) % 4;
      p  = ((k - 1) / 16) % 3;
      pn = (k / 16) % 3;
      push(base + k, "scan_loop", an_tab[s], seg_tab[p][s], 2'(pn), 1'b0, 4'hF);
    end
    step(61);
    start = 1'b0;
    push(cyc + 1, "idle_after_loop", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    step(1);

    // One-shot run
    base = cyc + 1;
    start = 1'b1;
    loop_mode = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      s  = ((k - 1) / 4) % 4;
      p  = (k - 1 < 16) ? 0 : ((k - 1 < 32) ? 1 : 2);
      pn = (k < 16) ? 0 : ((k < 32) ? 1 : 2);
      push(base + k, "oneshot", an_tab[s], seg_tab[p][s], 2'(pn), (k >= 48), 4'hF);
    end
    push(base + 100, "oneshot_hold", 4'h0, 7'h00, 2'd2, 1'b1, 4'b1100);
    push(base + 150, "oneshot_hold", 4'h0, 7'h00, 2'd2, 1'b1, 4'b1100);
    step(160);
    start = 1'b0;
    push(cyc + 1, "oneshot_stop", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    step(2);

    // Blanking digits 0 and 2
    base = cyc + 1;
    blank = 4'b0101;
    loop_mode = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      s  = ((k - 1) / 4) % 4;
      p  = (k - 1) / 16;
      pn = (k / 16) % 3;
      if (s == 0 || s == 2)
        push(base + k, "blank", 4'hF, 7'h7F, 2'(pn), 1'b0, 4'hF);
      else
        push(base + k, "blank", an_tab[s], seg_tab[p][s], 2'(pn), 1'b0, 4'hF);
    end
    step(33);
    start = 1'b0;
    blank = 4'b0000;
    step(1);

    // Abort on the cycle of the advancing tick
    base = cyc + 1;
    start = 1'b1;
    push(base + 15, "abort_pre", 4'h0, 7'h00, 2'd0, 1'b0, 4'b0100);
    push(base + 16, "abort_idle", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    push(base + 17, "abort_hold", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    step(16);
    start = 1'b0;
    step(2);
    base = cyc + 1;
    start = 1'b1;
    push(base + 1, "restart", 4'hE, 7'h40, 2'd0, 1'b0, 4'hF);
    push(base + 15, "restart_ph", 4'h0, 7'h00, 2'd0, 1'b0, 4'b1100);
    push(base + 16, "restart_adv", 4'h0, 7'h00, 2'd1, 1'b0, 4'b1100);
    step(20);

    // Asynchronous reset mid-run, checked before the next rising edge
    push(cyc, "reset_async", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    push(cyc + 1, "reset_held", 4'hF, 7'h7F, 2'd0, 1'b0, 4'hF);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    start = 1'b0;
    step(2);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s unchecked cyc=%0d got=none want=checked", e.nm, e.c);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
